// File: rtl/seq_pattern_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package seq_pattern_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap,
    StDone
  } state_e;

  localparam logic [3:0] PatDefault = 4'b1100;

endpackage

// File: rtl/seq_pattern_shreg.sv
// Parallel-load, MSB-first shift register; zeros enter at the LSB.
module seq_pattern_shreg #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         q_msb
);

  logic [W-1:0] q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {q[W-2:0], 1'b0};
    end
  end

  assign q_msb = q[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends reps+1 copies of a pattern MSB-first, gap idle cycles apart.
module seq_pattern_tx
  import seq_pattern_pkg::*;
#(
  parameter int unsigned      PAT_W       = 4,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(PatDefault)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_default,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [3:0]       reps,
  input  logic [2:0]       gap,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned    CntW    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [CntW-1:0] BitLast = CntW'(PAT_W - 1);

  state_e           state_q;
  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] load_pat;
  logic [3:0]       copies_q;
  logic [2:0]       gap_q;
  logic [2:0]       gap_cnt_q;
  logic [CntW-1:0]  bit_cnt_q;
  logic             sh_load;
  logic             sh_shift;
  logic             q_msb;

  // Shift-register control: load on acceptance or when the next copy begins.
  always_comb begin
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    load_pat = pat_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sh_load  = 1'b1;
          load_pat = use_default ? PAT_DEFAULT : pattern_in;
        end
      end
      StShift: begin
        if (bit_cnt_q == BitLast && copies_q != 4'd0 && gap_q == 3'd0) begin
          sh_load = 1'b1;
        end else begin
          sh_shift = 1'b1;
        end
      end
      StGap:   sh_load = (gap_cnt_q == 3'd1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pat_q     <= '0;
      copies_q  <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      bit_cnt_q <= '0;
      x_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StShift;
            pat_q     <= load_pat;
            copies_q  <= reps;
            gap_q     <= gap;
            bit_cnt_q <= '0;
            x_valid   <= 1'b1;
            busy      <= 1'b1;
          end
        end
        StShift: begin
          if (bit_cnt_q == BitLast) begin
            bit_cnt_q <= '0;
            if (copies_q == 4'd0) begin
              state_q <= StDone;
              x_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              copies_q <= copies_q - 4'd1;
              if (gap_q != 3'd0) begin
                state_q   <= StGap;
                gap_cnt_q <= gap_q;
                x_valid   <= 1'b0;
              end
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        StGap: begin
          gap_cnt_q <= gap_cnt_q - 3'd1;
          if (gap_cnt_q == 3'd1) begin
            state_q <= StShift;
            x_valid <= 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  seq_pattern_shreg #(
    .W(PAT_W)
  ) u_shreg (
    .clk  (clk),
    .rst  (rst),
    .load (sh_load),
    .shift(sh_shift),
    .d    (load_pat),
    .q_msb(q_msb)
  );

  assign x = x_valid & q_msb;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench with a per-cycle scoreboard of {x, x_valid, busy, done}.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       use_default;
  logic [3:0] pattern_in;
  logic [3:0] reps;
  logic [2:0] gap;
  logic       x;
  logic       x_valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected {x, x_valid, busy, done} for each upcoming cycle; empty means idle.
  logic [3:0] exp_q[$];

  seq_pattern_tx dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .use_default(use_default),
    .pattern_in (pattern_in),
    .reps       (reps),
    .gap        (gap),
    .x          (x),
    .x_valid    (x_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic void push_xfer(logic [3:0] pat, int n_reps, int n_gap);
    for (int c = 0; c <= n_reps; c++) begin
      for (int b = 3; b >= 0; b--) exp_q.push_back({pat[b], 3'b110});
      if (c < n_reps) begin
        for (int g = 0; g < n_gap; g++) exp_q.push_back(4'b0010);
      end
    end
    exp_q.push_back(4'b0001);
  endfunction

  task automatic tick(input string tag);
    logic [3:0] e;
    logic [3:0] obs;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    e   = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
    obs = {x, x_valid, busy, done};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s cyc %0d {x,x_valid,busy,done} got %b exp %b", tag, cyc, obs, e);
    end
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) tick(tag);
    tick(tag);
  endtask

  // Launch a transfer, then scramble the inputs so any leakage into the live transfer shows up.
  task automatic go(input string tag, input logic ud, input logic [3:0] pat, input logic [3:0] r,
                    input logic [2:0] g);
    use_default = ud;
    pattern_in  = pat;
    reps        = r;
    gap         = g;
    start       = 1'b1;
    push_xfer(ud ? 4'b1100 : pat, int'(r), int'(g));
    tick(tag);
    start       = 1'b0;
    use_default = ~ud;
    pattern_in  = ~pat;
    reps        = r ^ 4'h5;
    gap         = g ^ 3'h3;
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    use_default = 1'b0;
    pattern_in  = 4'h0;
    reps        = 4'h0;
    gap         = 3'h0;
    @(negedge clk);
    repeat (3) tick("reset");

    // Start in the very first cycle after reset release.
    rst = 1'b0;
    go("default_single", 1'b1, 4'b0101, 4'd0, 3'd0);
    drain("default_single");

    go("user_gap2", 1'b0, 4'b1011, 4'd1, 3'd2);
    drain("user_gap2");

    go("default_b2b", 1'b1, 4'b0000, 4'd2, 3'd0);
    drain("default_b2b");

    // Start held high: the second acceptance happens in the idle cycle after done.
    use_default = 1'b1;
    reps        = 4'd0;
    gap         = 3'd0;
    start       = 1'b1;
    push_xfer(4'b1100, 0, 0);
    exp_q.push_back(4'b0000);
    push_xfer(4'b1100, 0, 0);
    repeat (7) tick("start_held");
    start = 1'b0;
    drain("start_held");

    // Reset mid-transfer aborts without a done pulse.
    use_default = 1'b0;
    pattern_in  = 4'b1011;
    reps        = 4'd1;
    gap         = 3'd2;
    start       = 1'b1;
    exp_q.push_back(4'b1110);
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b1110);
    tick("rst_abort");
    start = 1'b0;
    tick("rst_abort");
    tick("rst_abort");
    rst = 1'b1;
    tick("rst_abort");
    rst = 1'b0;
    repeat (6) tick("rst_abort_idle");
    go("after_abort", 1'b0, 4'b1001, 4'd0, 3'd0);
    drain("after_abort");

    go("reps15", 1'b1, 4'b0000, 4'd15, 3'd0);
    drain("reps15");

    // Long gap with a stray start pulse in the middle of the transfer.
    go("gap7_stray", 1'b0, 4'b0110, 4'd1, 3'd7);
    repeat (5) tick("gap7_stray");
    start = 1'b1;
    tick("gap7_stray");
    start = 1'b0;
    drain("gap7_stray");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
